dmem_arbiter: RTL and testbench

- Shares the single read port of the data memory ROM between the CPU data port (port 0) and an auxiliary reader such as a display scanner (port 1).
- Decodes the memory-mapped switch address and serves it from an internal synchronized, debounced switch-status register instead of the ROM.
- Sits between the processor/aux logic and the ROM instance; the ROM returns data one clock after the address is presented.

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data ROM read port between the CPU (port 0) and
// an auxiliary reader (port 1); IO_ADDR is served from a debounced switch register.
module dmem_arbiter #(
   parameter logic [31:0] IO_ADDR         = 32'd254,
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter int          CNT_W           = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        switch1,
   input  logic        switch2,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        aux_req,
   input  logic [31:0] aux_addr,
   output logic        aux_gnt,
   output logic        aux_rvalid,
   output logic [31:0] aux_rdata,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {ST_STABLE, ST_CHANGING} db_state_e;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // {switch1, switch2} = 11 is not a legal setting and reads back as zero
   function automatic logic [1:0] io_value(input logic [1:0] st);
      return (st == 2'b11) ? 2'b00 : st;
   endfunction

   logic        vld_p0_q, vld_p0_d;
   logic        port_p0_q, port_p0_d;
   logic        io_p0_q, io_p0_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        last_aux_q, last_aux_d;

   logic        vld_p1_q, vld_p1_d;
   logic        port_p1_q, port_p1_d;
   logic        io_p1_q, io_p1_d;
   logic [31:0] cpu_hold_q, cpu_hold_d;
   logic [31:0] aux_hold_q, aux_hold_d;

   logic [1:0]       meta_q, meta_d;
   logic [1:0]       sync_q, sync_d;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       status_q, status_d;

   logic        pick_cpu, pick_aux;
   logic [31:0] resp_data;

   // Stage p0: arbitrate among live requests and register the grant tag
   always_comb begin
      pick_cpu   = cpu_req & (~aux_req | last_aux_q);
      pick_aux   = aux_req & ~pick_cpu;
      vld_p0_d   = pick_cpu | pick_aux;
      port_p0_d  = pick_aux;
      mem_addr_d = mem_addr_q;
      if (pick_cpu) begin
         mem_addr_d = cpu_addr;
      end else if (pick_aux) begin
         mem_addr_d = aux_addr;
      end
      io_p0_d    = vld_p0_d & (mem_addr_d == IO_ADDR);
      last_aux_d = vld_p0_d ? pick_aux : last_aux_q;
      vld_p1_d   = vld_p0_q;
      port_p1_d  = port_p0_q;
      io_p1_d    = io_p0_q;
   end

   assign cpu_gnt  = vld_p0_q & ~port_p0_q;
   assign aux_gnt  = vld_p0_q & port_p0_q;
   assign mem_addr = mem_addr_q;

   // Stage p1: ROM word arrives now; steer it (or switch status) to the tagged port
   always_comb begin
      resp_data  = io_p1_q ? {30'b0, io_value(status_q)} : mem_rdata;
      cpu_rvalid = vld_p1_q & ~port_p1_q;
      aux_rvalid = vld_p1_q & port_p1_q;
      cpu_rdata  = cpu_rvalid ? resp_data : cpu_hold_q;
      aux_rdata  = aux_rvalid ? resp_data : aux_hold_q;
      cpu_hold_d = cpu_rdata;
      aux_hold_d = aux_rdata;
   end

   // Switch debounce: cand_q remembers the value being timed so a second change restarts it
   always_comb begin
      meta_d   = {switch1, switch2};
      sync_d   = meta_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      status_d = status_q;
      case (state_q)
         ST_STABLE: begin
            cnt_d = '0;
            if (sync_q != status_q) begin
               state_d = ST_CHANGING;
               cand_d  = sync_q;
            end
         end
         ST_CHANGING: begin
            if (sync_q == status_q) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (sync_q != cand_q) begin
               cand_d = sync_q;
               cnt_d  = '0;
            end else if (cnt_q == DB_LAST) begin
               status_d = sync_q;
               state_d  = ST_STABLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0_q   <= 1'b0;
         port_p0_q  <= 1'b0;
         io_p0_q    <= 1'b0;
         mem_addr_q <= '0;
         last_aux_q <= 1'b1;
         vld_p1_q   <= 1'b0;
         port_p1_q  <= 1'b0;
         io_p1_q    <= 1'b0;
         cpu_hold_q <= '0;
         aux_hold_q <= '0;
         meta_q     <= '0;
         sync_q     <= '0;
         state_q    <= ST_STABLE;
         cnt_q      <= '0;
         cand_q     <= '0;
         status_q   <= '0;
      end else begin
         vld_p0_q   <= vld_p0_d;
         port_p0_q  <= port_p0_d;
         io_p0_q    <= io_p0_d;
         mem_addr_q <= mem_addr_d;
         last_aux_q <= last_aux_d;
         vld_p1_q   <= vld_p1_d;
         port_p1_q  <= port_p1_d;
         io_p1_q    <= io_p1_d;
         cpu_hold_q <= cpu_hold_d;
         aux_hold_q <= aux_hold_d;
         meta_q     <= meta_d;
         sync_q     <= sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         status_q   <= status_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a cycle-level reference model and a behavioural ROM.
module tb_dmem_arbiter;

   localparam logic [31:0] IO_ADDR = 32'd254;
   localparam int          DB      = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        switch1, switch2;
   logic        cpu_req, aux_req;
   logic [31:0] cpu_addr, aux_addr;
   logic        cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
   logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_rdata;

   int n_chk = 0;
   int n_err = 0;

   dmem_arbiter #(.IO_ADDR(IO_ADDR), .DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .switch1(switch1), .switch2(switch2),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
      .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous-read ROM: data for the address presented in one cycle shows up in the next
   always @(posedge clk) mem_rdata <= rom_word(mem_addr);

   // Reference model state (values expected during the current cycle)
   logic        m_gnt_cpu, m_gnt_aux, m_rv_cpu, m_rv_aux, m_io;
   logic [31:0] m_addr, m_rd_cpu, m_rd_aux;
   int          m_last;
   logic [1:0]  sync_pipe[$];
   logic [1:0]  m_status, m_prev;
   int          m_run;

   function automatic logic [1:0] sw_value(input logic [1:0] p);
      return (p == 2'b11) ? 2'b00 : p;
   endfunction

   task automatic model_reset();
      m_gnt_cpu = 0; m_gnt_aux = 0; m_rv_cpu = 0; m_rv_aux = 0; m_io = 0;
      m_addr = 0; m_rd_cpu = 0; m_rd_aux = 0; m_last = 1;
      sync_pipe = {2'b00, 2'b00};
      m_status = 0; m_prev = 0; m_run = 0;
   endtask

   task automatic model_edge();
      logic [1:0]  s;
      logic [31:0] resp;
      int          winner;
      // switches: status follows a synchronized value once it persists DB+1 samples
      s = sync_pipe[0];
      if (s == m_status) m_run = 0;
      else if (s == m_prev) m_run++;
      else m_run = 1;
      if (m_run == DB + 1) begin
         m_status = s;
         m_run = 0;
      end
      m_prev = s;
      void'(sync_pipe.pop_front());
      sync_pipe.push_back({switch1, switch2});
      // responses for whatever was granted in the cycle just ending
      m_rv_cpu = m_gnt_cpu;
      m_rv_aux = m_gnt_aux;
      resp = m_io ? {30'b0, sw_value(m_status)} : rom_word(m_addr);
      if (m_rv_cpu) m_rd_cpu = resp;
      if (m_rv_aux) m_rd_aux = resp;
      // round-robin choice
      winner = -1;
      if (cpu_req && aux_req) winner = 1 - m_last;
      else if (cpu_req) winner = 0;
      else if (aux_req) winner = 1;
      m_gnt_cpu = (winner == 0);
      m_gnt_aux = (winner == 1);
      if (winner >= 0) begin
         m_addr = (winner == 1) ? aux_addr : cpu_addr;
         m_io = (m_addr == IO_ADDR);
         m_last = winner;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare();
      chk("cpu_gnt", 32'(cpu_gnt), 32'(m_gnt_cpu));
      chk("aux_gnt", 32'(aux_gnt), 32'(m_gnt_aux));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv_cpu));
      chk("aux_rvalid", 32'(aux_rvalid), 32'(m_rv_aux));
      chk("cpu_rdata", cpu_rdata, m_rd_cpu);
      chk("aux_rdata", aux_rdata, m_rd_aux);
      chk("mem_addr", mem_addr, m_addr);
   endtask

   // Inputs change at negedge; one clock passes; outputs compared at the next negedge
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_reset();
      reset = 1;
      model_reset();
      tick();
      reset = 0;
   endtask

   task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
      cpu_req = 1; cpu_addr = a;
      tick();
      cpu_req = 0;
      tick();
      d = cpu_rdata;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 3))
         0: return IO_ADDR;
         1: return {24'b0, 6'($urandom_range(0, 63)), 2'b00};
         2: return $urandom;
         default: return IO_ADDR ^ (32'd1 << $urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      logic [31:0] d;
      reset = 1; switch1 = 0; switch2 = 0;
      cpu_req = 0; aux_req = 0; cpu_addr = 0; aux_addr = 0;
      model_reset();
      ticks(3);
      chk("rst_mem_addr", mem_addr, 32'h0);
      reset = 0;

      // single CPU read
      cpu_req = 1; cpu_addr = 32'h10;
      tick();
      chk("t1_gnt", 32'(cpu_gnt), 32'd1);
      cpu_req = 0;
      tick();
      chk("t1_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("t1_aux_idle", {aux_rdata[29:0], aux_gnt, aux_rvalid}, 32'h0);
      tick();

      // both requesting continuously: strict alternation starting with the CPU
      pulse_reset();
      cpu_req = 1; cpu_addr = 32'h4; aux_req = 1; aux_addr = 32'h8;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rr_order", {30'b0, cpu_gnt, aux_gnt}, (i % 2 == 1) ? 32'd1 : 32'd2);
         if (i > 0) chk("rr_resp", (i % 2 == 1) ? cpu_rdata : aux_rdata,
                        (i % 2 == 1) ? rom_word(32'h4) : rom_word(32'h8));
      end
      cpu_req = 0; aux_req = 0;
      ticks(2);

      // debounced switches
      switch1 = 0; switch2 = 1;
      ticks(DB + 3);
      cpu_read(IO_ADDR, d);
      chk("io_01", d, 32'd1);
      switch1 = 1; switch2 = 1;
      ticks(DB + 6);
      cpu_read(IO_ADDR, d);
      chk("io_11", d, 32'd0);

      // bouncing switch2 never settles long enough
      switch1 = 0;
      for (int t = 0; t < 8; t++) begin
         switch2 = ~switch2;
         for (int j = 0; j < 5; j++) begin
            cpu_req = (j == 0); cpu_addr = IO_ADDR;
            tick();
            if (j == 1) chk("bounce_io", cpu_rdata, 32'd0);
         end
      end
      switch2 = 1;
      ticks(20);
      cpu_read(IO_ADDR, d);
      chk("settled_io", d, 32'd1);

      // reset while an aux response is in flight
      aux_req = 1; aux_addr = 32'h30;
      tick();
      chk("rst_aux_gnt", 32'(aux_gnt), 32'd1);
      cpu_req = 1; cpu_addr = 32'h40;
      reset = 1;
      model_reset();
      #1;
      chk("rst_outs", {cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_addr[27:0]}, 32'h0);
      chk("rst_rdata", cpu_rdata | aux_rdata, 32'h0);
      @(negedge clk);
      compare();
      tick();
      chk("rst_no_rvalid", 32'(aux_rvalid), 32'd0);
      reset = 0;
      tick();
      chk("post_rst_cpu_first", {30'b0, cpu_gnt, aux_gnt}, 32'd2);
      cpu_req = 0; aux_req = 0;
      ticks(DB + 6);

      // aux reads switch status while the CPU reads ROM, interleaved
      cpu_req = 1; cpu_addr = 32'h20; aux_req = 1; aux_addr = IO_ADDR;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (aux_rvalid) chk("mix_aux", aux_rdata, 32'd1);
         if (cpu_rvalid) chk("mix_cpu", cpu_rdata, rom_word(32'h20));
      end
      cpu_req = 0; aux_req = 0;
      ticks(2);

      // random traffic, switch activity and occasional resets
      for (int c = 0; c < 3000; c++) begin
         if (!cpu_req || m_gnt_cpu) begin
            cpu_req = ($urandom_range(0, 2) != 0);
            cpu_addr = pick_addr();
         end
         if (!aux_req || m_gnt_aux) begin
            aux_req = ($urandom_range(0, 2) != 0);
            aux_addr = pick_addr();
         end
         if ($urandom_range(0, 39) == 0) switch1 = ~switch1;
         if ($urandom_range(0, 39) == 0) switch2 = ~switch2;
         reset = ($urandom_range(0, 299) == 0);
         if (reset) model_reset();
         tick();
      end
      reset = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
